nn_sample_sequencer: RTL and testbench
======================================

Name: nn_sample_sequencer

Overview:
- Drives the four signed input buses of the FeedForwardNN core and waits its fixed compute latency.
- Captures y0/y1 and hands the result downstream over a valid/ready stream.
- Upstream samples also arrive over a valid/ready stream.
- Replaces free-running, file-timed stimulus with a handshaked initiator, so the NN core can be embedded in a datapath.

Parameters:
- WWDITH, 32, base data width; NN inputs are WWDITH+1 bits signed, NN outputs are 2*WWDITH+1 bits signed.
- LATENCY, 24, CLK cycles from an nn_x update to valid nn_y; legal range 1..65535.
- CNT_W, 16, width of the latency counter and of sample_count.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_x0..in_x3  in  WWDITH+1 each  signed sample features.
- nn_x0..nn_x3  out  WWDITH+1 each  registered drive to the NN core x0..x3.
- nn_y0, nn_y1  in  2*WWDITH+1 each  NN core outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y0, out_y1  out  2*WWDITH+1 each  captured results, signed.
- busy  out  1  high in WAIT or HOLD.
- sample_count  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Reset (RST high at an edge):
  - State becomes IDLE.
  - nn_x*, out_y*, out_valid, busy and sample_count are all cleared to 0.
  - in_ready is combinational (state==IDLE) & ~RST, so it is 0 while RST is high.
- Reset mid-operation aborts everything: any in-flight or pending result is discarded and never presented.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge k: nn_x0..3 <= in_x0..3, cnt <= LATENCY-1, go to WAIT.
- FSM WAIT:
  - in_ready=0.
  - At each edge: if cnt==0, then out_y0<=nn_y0, out_y1<=nn_y1, out_valid<=1, go to HOLD; else cnt<=cnt-1.
  - Capture therefore occurs at edge k+LATENCY; out_valid is first seen high after that edge.
- FSM HOLD:
  - out_valid=1 and out_y* are stable.
  - On out_valid&out_ready: out_valid<=0, sample_count<=sample_count+1, go to IDLE.
  - Next accept is possible at the following edge.
- nn_x* hold their value through WAIT, HOLD and IDLE until the next accept; they are never changed mid-computation.
- out_y* hold the last captured value after the handshake until the next capture.
- Throughput: one sample per LATENCY+2 cycles minimum (accept, LATENCY waits, 1-cycle handshake, return to IDLE).
- Sample-stream rules:
  - in_valid without in_ready is ignored; the sample is not consumed.
  - Upstream must hold the sample stable until accepted.
  - A deassertion of out_ready in HOLD stalls indefinitely without losing data.
- nn_y is only sampled at the capture edge; glitches or changes on nn_y at any other time have no effect.
- Width rule: values pass through unmodified, with no truncation, sign extension or rounding.

Optional Feature:
- Macro SEQ_ARGMAX_EN.
- When defined:
  - Adds output port out_class (1 bit), registered at the capture edge.
  - out_class=1 iff signed nn_y1 > nn_y0; a tie gives 0.
  - Reset value 0; held through HOLD.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert RST 2 cycles mid-WAIT -> next edge out_valid=0, nn_x*=0, sample_count=0, in_ready=1 one cycle after RST drops; no stale result ever presented.
- Basic, LATENCY=24: accept x=(1,2,3,4) at edge k, model nn_y0=10, nn_y1=-5 -> out_valid rises after edge k+24, out_y0=10, out_y1=-5, in_ready=0 from edge k through HOLD.
- Backpressure: out_ready=0 for 50 cycles in HOLD -> out_valid and out_y stay constant, in_ready=0, in_valid with new data not consumed; release -> handshake, sample_count +1, next sample accepted following edge.
- Signed extremes: in_x0=-2^32, in_x3=2^32-1; nn_y0=-(2^64) -> nn_x and out_y bit-exact, sign preserved.
- Boundary: LATENCY=1 -> capture at edge k+1; nn_y changed at edges k+2..k+5 does not alter out_y. sample_count with CNT_W=4 after 17 results reads 1.
- SEQ_ARGMAX_EN: y0=7, y1=7 -> out_class=0; y0=-3, y1=-2 -> 1; y0=5, y1=-9 -> 0.

Source files
------------

// File: rtl/nn_sample_sequencer_if.sv
// Valid/ready sample stream (in_*) and result stream (out_*) of nn_sample_sequencer.
// The master modport is the sequencer side; slave is the upstream/downstream side.
interface nn_sample_sequencer_if #(
  parameter int WWDITH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WWDITH:0]  in_x0;
  logic signed [WWDITH:0]  in_x1;
  logic signed [WWDITH:0]  in_x2;
  logic signed [WWDITH:0]  in_x3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [2*WWDITH:0] out_y0;
  logic signed [2*WWDITH:0] out_y1;

  modport master (
    input  in_valid, in_x0, in_x1, in_x2, in_x3, out_ready,
    output in_ready, out_valid, out_y0, out_y1
  );

  modport slave (
    output in_valid, in_x0, in_x1, in_x2, in_x3, out_ready,
    input  in_ready, out_valid, out_y0, out_y1
  );
endinterface

// File: rtl/nn_sample_sequencer.sv
// Handshaked initiator for the FeedForwardNN core: accepts a sample, waits LATENCY cycles, presents y0/y1.
// Define SEQ_ARGMAX_EN to add out_class (1 when signed nn_y1 > nn_y0).
module nn_sample_sequencer #(
  parameter int WWDITH  = 32,
  parameter int LATENCY = 24,
  parameter int CNT_W   = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  nn_sample_sequencer_if.master     stream,
  output logic signed [WWDITH:0]    nn_x0,
  output logic signed [WWDITH:0]    nn_x1,
  output logic signed [WWDITH:0]    nn_x2,
  output logic signed [WWDITH:0]    nn_x3,
  input  logic signed [2*WWDITH:0]  nn_y0,
  input  logic signed [2*WWDITH:0]  nn_y1,
  output logic                      busy,
  output logic [CNT_W-1:0]          sample_count
`ifdef SEQ_ARGMAX_EN
  ,
  output logic                      out_class
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;
  logic             handoff;

  assign stream.in_ready = (state == ST_IDLE) & ~RST;
  assign busy            = (state != ST_IDLE);
  assign accept          = stream.in_valid & stream.in_ready;
  assign capture         = (state == ST_WAIT) && (cnt == '0);
  assign handoff         = stream.out_valid & stream.out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)  state_next = ST_WAIT;
      ST_WAIT: if (capture) state_next = ST_HOLD;
      ST_HOLD: if (handoff) state_next = ST_IDLE;
      default:              state_next = ST_IDLE;
    endcase
  end

  // nn_x only moves on accept, so the core never sees its inputs change mid-computation
  always_ff @(posedge CLK) begin
    if (RST) begin
      nn_x0            <= '0;
      nn_x1            <= '0;
      nn_x2            <= '0;
      nn_x3            <= '0;
      cnt              <= '0;
      stream.out_y0    <= '0;
      stream.out_y1    <= '0;
      stream.out_valid <= 1'b0;
      sample_count     <= '0;
    end else begin
      if (accept) begin
        nn_x0 <= stream.in_x0;
        nn_x1 <= stream.in_x1;
        nn_x2 <= stream.in_x2;
        nn_x3 <= stream.in_x3;
        cnt   <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (capture) begin
        stream.out_y0    <= nn_y0;
        stream.out_y1    <= nn_y1;
        stream.out_valid <= 1'b1;
      end else if (handoff) begin
        stream.out_valid <= 1'b0;
        sample_count     <= sample_count + 1'b1;
      end
    end
  end

`ifdef SEQ_ARGMAX_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_class <= 1'b0;
    end else if (capture) begin
      out_class <= (nn_y1 > nn_y0);
    end
  end
`endif

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Bench for nn_sample_sequencer: instance A (LATENCY=24, CNT_W=16) and B (LATENCY=1, CNT_W=4) vs. a cycle-indexed model.
// Define SEQ_ARGMAX_EN to also check out_class.
module tb_nn_sample_sequencer;
  localparam int W     = 32;
  localparam int LAT_A = 24;
  localparam int LAT_B = 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  nn_sample_sequencer_if #(.WWDITH(W)) sa ();
  nn_sample_sequencer_if #(.WWDITH(W)) sb ();

  logic signed [W:0]   ax0, ax1, ax2, ax3, bx0, bx1, bx2, bx3;
  logic signed [2*W:0] ay0, ay1, by0, by1;
  logic                abusy, bbusy;
  logic [15:0]         acount;
  logic [3:0]          bcount;
`ifdef SEQ_ARGMAX_EN
  logic                aclass, bclass;
`endif

  nn_sample_sequencer #(.WWDITH(W), .LATENCY(LAT_A), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .stream(sa),
    .nn_x0(ax0), .nn_x1(ax1), .nn_x2(ax2), .nn_x3(ax3),
    .nn_y0(ay0), .nn_y1(ay1), .busy(abusy), .sample_count(acount)
`ifdef SEQ_ARGMAX_EN
    , .out_class(aclass)
`endif
  );

  nn_sample_sequencer #(.WWDITH(W), .LATENCY(LAT_B), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .stream(sb),
    .nn_x0(bx0), .nn_x1(bx1), .nn_x2(bx2), .nn_x3(bx3),
    .nn_y0(by0), .nn_y1(by1), .busy(bbusy), .sample_count(bcount)
`ifdef SEQ_ARGMAX_EN
    , .out_class(bclass)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int unsigned sc_a = 0;
  bit y_rand = 1'b0;
  logic signed [2*W:0] ylog0 [int];
  logic signed [2*W:0] ylog1 [int];

  // Model of the core outputs: ylog[n] is what nn_y held at rising edge n
  always @(posedge CLK) begin
    ylog0[cyc + 1] = ay0;
    ylog1[cyc + 1] = ay1;
    cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (y_rand) begin
      ay0 = rand_y();
      ay1 = rand_y();
    end
  end

  function automatic logic signed [2*W:0] rand_y();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[2*W:0];
  endfunction

  function automatic logic signed [W:0] rand_x();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W:0];
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    sa.in_valid = 1'b0; sa.out_ready = 1'b0;
    sa.in_x0 = '0; sa.in_x1 = '0; sa.in_x2 = '0; sa.in_x3 = '0;
    sb.in_valid = 1'b0; sb.out_ready = 1'b0;
    sb.in_x0 = '0; sb.in_x1 = '0; sb.in_x2 = '0; sb.in_x3 = '0;
    ay0 = '0; ay1 = '0; by0 = '0; by1 = '0;
    y_rand = 1'b0;
    tick();
    tick();
    checks++; if (sa.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready_low: got %b want 0", sa.in_ready); end
    checks++; if (sa.out_valid !== 1'b0 || abusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_busy: got %b %b want 0 0", sa.out_valid, abusy); end
    checks++; if ({ax0, ax1, ax2, ax3} !== '0) begin failures++; $display("[TB] FAIL reset_nn_x: got %h %h %h %h want 0", ax0, ax1, ax2, ax3); end
    checks++; if (acount !== 16'd0 || sa.out_y0 !== '0 || sa.out_y1 !== '0) begin failures++; $display("[TB] FAIL reset_count_y: got %0d %h %h want 0", acount, sa.out_y0, sa.out_y1); end
    RST = 1'b0;
    #1;
    checks++; if (sa.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", sa.in_ready); end
    tick();
    checks++; if (sa.in_ready !== 1'b1 || abusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle: got %b %b want 1 0", sa.in_ready, abusy); end
  endtask

  task automatic test_basic();
    int k;
    logic signed [2*W:0] e0, e1;
    e0 = 10; e1 = -5;
    y_rand = 1'b0; ay0 = e0; ay1 = e1;
    checks++; if (sa.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_in_ready_idle: got %b want 1", sa.in_ready); end
    sa.in_x0 = 1; sa.in_x1 = 2; sa.in_x2 = 3; sa.in_x3 = 4; sa.in_valid = 1'b1; sa.out_ready = 1'b0;
    tick(); k = cyc;
    sa.in_valid = 1'b0;
    checks++; if (ax0 !== 1 || ax1 !== 2 || ax2 !== 3 || ax3 !== 4) begin failures++; $display("[TB] FAIL basic_nn_x: got %0d %0d %0d %0d want 1 2 3 4", ax0, ax1, ax2, ax3); end
    checks++; if (sa.in_ready !== 1'b0 || abusy !== 1'b1) begin failures++; $display("[TB] FAIL basic_after_accept: got ready=%b busy=%b want 0 1", sa.in_ready, abusy); end
    for (int i = 1; i < LAT_A; i++) begin
      tick();
      checks++; if (sa.out_valid !== 1'b0 || sa.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_wait: at k+%0d got valid=%b ready=%b want 0 0", cyc - k, sa.out_valid, sa.in_ready); end
    end
    tick();
    checks++; if (sa.out_valid !== 1'b1 || sa.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_out_valid: got valid=%b ready=%b want 1 0", sa.out_valid, sa.in_ready); end
    checks++; if (sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL basic_out_y: got %0d %0d want 10 -5", sa.out_y0, sa.out_y1); end
    sa.out_ready = 1'b1;
    tick(); sc_a++;
    sa.out_ready = 1'b0;
    checks++; if (sa.out_valid !== 1'b0 || acount !== sc_a[15:0]) begin failures++; $display("[TB] FAIL basic_handshake: got valid=%b count=%0d want 0 %0d", sa.out_valid, acount, sc_a[15:0]); end
    checks++; if (sa.in_ready !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL basic_after_handshake: got ready=%b y=%0d %0d want 1 10 -5", sa.in_ready, sa.out_y0, sa.out_y1); end
  endtask

  task automatic test_backpressure();
    int k, k2;
    logic signed [W:0] x0, x1, x2, x3, n0, n1, n2, n3;
    logic signed [2*W:0] e0, e1;
    y_rand = 1'b1;
    x0 = rand_x(); x1 = rand_x(); x2 = rand_x(); x3 = rand_x();
    n0 = rand_x(); n1 = rand_x(); n2 = rand_x(); n3 = rand_x();
    sa.in_x0 = x0; sa.in_x1 = x1; sa.in_x2 = x2; sa.in_x3 = x3; sa.in_valid = 1'b1; sa.out_ready = 1'b0;
    tick(); k = cyc;
    sa.in_valid = 1'b0;
    repeat (LAT_A) tick();
    e0 = ylog0[k + LAT_A]; e1 = ylog1[k + LAT_A];
    checks++; if (sa.out_valid !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL bp_capture: got %b %h %h want 1 %h %h", sa.out_valid, sa.out_y0, sa.out_y1, e0, e1); end
    sa.in_x0 = n0; sa.in_x1 = n1; sa.in_x2 = n2; sa.in_x3 = n3; sa.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if (sa.out_valid !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL bp_hold_out: stall %0d got %b %h %h want 1 %h %h", i, sa.out_valid, sa.out_y0, sa.out_y1, e0, e1); end
      checks++; if (sa.in_ready !== 1'b0 || ax0 !== x0 || ax3 !== x3) begin failures++; $display("[TB] FAIL bp_not_consumed: stall %0d got ready=%b x0=%h x3=%h want 0 %h %h", i, sa.in_ready, ax0, ax3, x0, x3); end
    end
    sa.out_ready = 1'b1;
    tick(); sc_a++;
    sa.out_ready = 1'b0;
    checks++; if (sa.out_valid !== 1'b0 || acount !== sc_a[15:0] || sa.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release: got valid=%b count=%0d ready=%b want 0 %0d 1", sa.out_valid, acount, sa.in_ready, sc_a[15:0]); end
    tick(); k2 = cyc;
    sa.in_valid = 1'b0;
    checks++; if (ax0 !== n0 || ax1 !== n1 || ax2 !== n2 || ax3 !== n3 || abusy !== 1'b1) begin failures++; $display("[TB] FAIL bp_next_accept: got %h %h %h %h busy=%b want %h %h %h %h 1", ax0, ax1, ax2, ax3, abusy, n0, n1, n2, n3); end
    repeat (LAT_A) tick();
    e0 = ylog0[k2 + LAT_A]; e1 = ylog1[k2 + LAT_A];
    checks++; if (sa.out_valid !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL bp_second_capture: got %b %h %h want 1 %h %h", sa.out_valid, sa.out_y0, sa.out_y1, e0, e1); end
    sa.out_ready = 1'b1;
    tick(); sc_a++;
    sa.out_ready = 1'b0;
    checks++; if (sa.out_valid !== 1'b0 || acount !== sc_a[15:0]) begin failures++; $display("[TB] FAIL bp_second_release: got %b %0d want 0 %0d", sa.out_valid, acount, sc_a[15:0]); end
  endtask

  task automatic test_extremes();
    logic signed [W:0] x0, x1, x2, x3;
    logic signed [2*W:0] e0, e1;
    x0 = {1'b1, {W{1'b0}}}; x1 = '1; x2 = '0; x3 = {1'b0, {W{1'b1}}};
    e0 = {1'b1, {(2*W){1'b0}}}; e1 = {1'b0, {(2*W){1'b1}}};
    y_rand = 1'b0; ay0 = e0; ay1 = e1;
    sa.in_x0 = x0; sa.in_x1 = x1; sa.in_x2 = x2; sa.in_x3 = x3; sa.in_valid = 1'b1;
    tick();
    sa.in_valid = 1'b0;
    checks++; if (ax0 !== x0 || ax1 !== x1 || ax2 !== x2 || ax3 !== x3) begin failures++; $display("[TB] FAIL ext_nn_x: got %h %h %h %h want %h %h %h %h", ax0, ax1, ax2, ax3, x0, x1, x2, x3); end
    checks++; if (!(ax0 < 0) || !(ax3 > 0)) begin failures++; $display("[TB] FAIL ext_x_sign: got x0=%0d x3=%0d want negative positive", ax0, ax3); end
    repeat (LAT_A) tick();
    checks++; if (sa.out_valid !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL ext_out_y: got %b %h %h want 1 %h %h", sa.out_valid, sa.out_y0, sa.out_y1, e0, e1); end
    checks++; if (!(sa.out_y0 < 0) || !(sa.out_y1 > 0)) begin failures++; $display("[TB] FAIL ext_y_sign: got y0=%0d y1=%0d want negative positive", sa.out_y0, sa.out_y1); end
    sa.out_ready = 1'b1;
    tick(); sc_a++;
    sa.out_ready = 1'b0;
    checks++; if (sa.out_valid !== 1'b0 || acount !== sc_a[15:0]) begin failures++; $display("[TB] FAIL ext_release: got %b %0d want 0 %0d", sa.out_valid, acount, sc_a[15:0]); end
  endtask

  task automatic test_random();
    int k, gap, stall;
    logic signed [W:0] x0, x1, x2, x3;
    logic signed [2*W:0] e0, e1;
    y_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        checks++; if (sa.in_ready !== 1'b1 || abusy !== 1'b0) begin failures++; $display("[TB] FAIL rand_idle: txn %0d got ready=%b busy=%b want 1 0", t, sa.in_ready, abusy); end
        tick();
      end
      x0 = rand_x(); x1 = rand_x(); x2 = rand_x(); x3 = rand_x();
      sa.in_x0 = x0; sa.in_x1 = x1; sa.in_x2 = x2; sa.in_x3 = x3; sa.in_valid = 1'b1;
      tick(); k = cyc;
      for (int i = 1; i < LAT_A; i++) begin
        sa.in_valid = 1'($urandom_range(0, 1));
        sa.in_x0 = rand_x(); sa.in_x1 = rand_x(); sa.in_x2 = rand_x(); sa.in_x3 = rand_x();
        tick();
        checks++; if (sa.out_valid !== 1'b0 || ax0 !== x0 || ax1 !== x1 || ax2 !== x2 || ax3 !== x3) begin failures++; $display("[TB] FAIL rand_wait: txn %0d k+%0d got valid=%b x0=%h want 0 %h", t, cyc - k, sa.out_valid, ax0, x0); end
      end
      sa.in_valid = 1'b0;
      tick();
      e0 = ylog0[k + LAT_A]; e1 = ylog1[k + LAT_A];
      checks++; if (sa.out_valid !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL rand_capture: txn %0d got %b %h %h want 1 %h %h", t, sa.out_valid, sa.out_y0, sa.out_y1, e0, e1); end
`ifdef SEQ_ARGMAX_EN
      checks++; if (aclass !== (e1 > e0)) begin failures++; $display("[TB] FAIL rand_class: txn %0d got %b want %b", t, aclass, (e1 > e0)); end
`endif
      stall = $urandom_range(0, 5);
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++; if (sa.out_valid !== 1'b1 || sa.out_y0 !== e0 || sa.out_y1 !== e1) begin failures++; $display("[TB] FAIL rand_stall: txn %0d got %b %h %h want 1 %h %h", t, sa.out_valid, sa.out_y0, sa.out_y1, e0, e1); end
      end
      sa.out_ready = 1'b1;
      tick(); sc_a++;
      sa.out_ready = 1'b0;
      checks++; if (sa.out_valid !== 1'b0 || acount !== sc_a[15:0]) begin failures++; $display("[TB] FAIL rand_release: txn %0d got %b %0d want 0 %0d", t, sa.out_valid, acount, sc_a[15:0]); end
    end
  endtask

`ifdef SEQ_ARGMAX_EN
  task automatic test_argmax();
    logic signed [2*W:0] ya [3];
    logic signed [2*W:0] yb [3];
    logic                exp_class [3];
    ya = '{65'sd7, -65'sd3, 65'sd5};
    yb = '{65'sd7, -65'sd2, -65'sd9};
    exp_class = '{1'b0, 1'b1, 1'b0};
    y_rand = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ay0 = ya[c]; ay1 = yb[c];
      sa.in_x0 = rand_x(); sa.in_x1 = rand_x(); sa.in_x2 = rand_x(); sa.in_x3 = rand_x(); sa.in_valid = 1'b1;
      tick();
      sa.in_valid = 1'b0;
      repeat (LAT_A) tick();
      checks++; if (sa.out_valid !== 1'b1 || aclass !== exp_class[c]) begin failures++; $display("[TB] FAIL argmax_class: case %0d got valid=%b class=%b want 1 %b", c, sa.out_valid, aclass, exp_class[c]); end
      tick();
      checks++; if (aclass !== exp_class[c]) begin failures++; $display("[TB] FAIL argmax_hold: case %0d got %b want %b", c, aclass, exp_class[c]); end
      sa.out_ready = 1'b1;
      tick(); sc_a++;
      sa.out_ready = 1'b0;
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    y_rand = 1'b1;
    sa.in_x0 = rand_x(); sa.in_x1 = rand_x(); sa.in_x2 = rand_x(); sa.in_x3 = rand_x(); sa.in_valid = 1'b1;
    tick();
    sa.in_valid = 1'b0;
    repeat (5) tick();
    RST = 1'b1;
    tick();
    sc_a = 0;
    checks++; if (sa.out_valid !== 1'b0 || abusy !== 1'b0 || sa.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_ctrl: got valid=%b busy=%b ready=%b want 0 0 0", sa.out_valid, abusy, sa.in_ready); end
    checks++; if ({ax0, ax1, ax2, ax3} !== '0 || acount !== 16'd0) begin failures++; $display("[TB] FAIL rst_mid_data: got x0=%h count=%0d want 0 0", ax0, acount); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (sa.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_ready: got %b want 1", sa.in_ready); end
    for (int i = 0; i < LAT_A + 5; i++) begin
      tick();
      checks++; if (sa.out_valid !== 1'b0 || abusy !== 1'b0 || sa.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_stale: cycle %0d got valid=%b busy=%b ready=%b want 0 0 1", i, sa.out_valid, abusy, sa.in_ready); end
    end
  endtask

  task automatic test_latency1();
    int unsigned n_done;
    logic signed [2*W:0] e0, e1;
    logic [3:0] exp_cnt;
    n_done = 0;
    for (int n = 1; n <= 17; n++) begin
      checks++; if (sb.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL lat1_ready: result %0d got %b want 1", n, sb.in_ready); end
      e0 = n * 3; e1 = -n;
      by0 = e0; by1 = e1;
      sb.in_x0 = n; sb.in_x1 = -n; sb.in_x2 = 0; sb.in_x3 = n; sb.in_valid = 1'b1; sb.out_ready = 1'b0;
      tick();
      sb.in_valid = 1'b0;
      checks++; if (sb.out_valid !== 1'b0 || bx0 !== n || bx1 !== -n) begin failures++; $display("[TB] FAIL lat1_accept: result %0d got valid=%b x0=%0d x1=%0d want 0 %0d %0d", n, sb.out_valid, bx0, bx1, n, -n); end
      tick();
      checks++; if (sb.out_valid !== 1'b1 || sb.out_y0 !== e0 || sb.out_y1 !== e1) begin failures++; $display("[TB] FAIL lat1_capture: result %0d got %b %0d %0d want 1 %0d %0d", n, sb.out_valid, sb.out_y0, sb.out_y1, e0, e1); end
      if (n == 1) begin
        for (int i = 0; i < 4; i++) begin
          by0 = rand_y(); by1 = rand_y();
          tick();
          checks++; if (sb.out_valid !== 1'b1 || sb.out_y0 !== e0 || sb.out_y1 !== e1) begin failures++; $display("[TB] FAIL lat1_glitch: k+%0d got %h %h want %h %h", i + 2, sb.out_y0, sb.out_y1, e0, e1); end
        end
      end
      sb.out_ready = 1'b1;
      tick(); n_done++;
      sb.out_ready = 1'b0;
      exp_cnt = 4'(n_done % 16);
      checks++; if (sb.out_valid !== 1'b0 || bcount !== exp_cnt) begin failures++; $display("[TB] FAIL lat1_count: result %0d got valid=%b count=%0d want 0 %0d", n, sb.out_valid, bcount, exp_cnt); end
    end
    checks++; if (bcount !== 4'd1) begin failures++; $display("[TB] FAIL lat1_wrap: got %0d want 1", bcount); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_extremes();
    test_random();
`ifdef SEQ_ARGMAX_EN
    test_argmax();
`endif
    test_reset_mid_wait();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
